// File: rtl/rom_port_arbiter_if.sv
// Bundles the two requester ports and the shared read-data return of rom_port_arbiter.
interface rom_port_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  reqA;
  logic [ADDR_WIDTH-1:0] addrA;
  logic                  lockA;
  logic                  gntA;
  logic                  validA;
  logic                  reqB;
  logic [ADDR_WIDTH-1:0] addrB;
  logic                  lockB;
  logic                  gntB;
  logic                  validB;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output reqA, addrA, lockA, reqB, addrB, lockB,
    input  gntA, validA, gntB, validB, rdata
  );

  modport slave (
    input  reqA, addrA, lockA, reqB, addrB, lockB,
    output gntA, validA, gntB, validB, rdata
  );
endinterface

// File: rtl/rom_port_arbiter.sv
// Round-robin arbiter with lockable bursts sharing a 1-cycle registered ROM between two readers.
// Optional ROM_ARB_STATS_EN adds saturating grant/conflict counters.
module rom_port_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_LOCK   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rom_port_arbiter_if.slave     bus,
  output logic [ADDR_WIDTH-1:0] romAddr_o,
  input  logic [DATA_WIDTH-1:0] romData_i
`ifdef ROM_ARB_STATS_EN
  ,
  output logic [15:0]           gntCntA_o,
  output logic [15:0]           gntCntB_o,
  output logic [15:0]           conflictCnt_o
`endif
);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  localparam logic [7:0] MaxLock = 8'(MAX_LOCK);

  state_t                state_q, state_d;
  logic                  rrPtr_q, rrPtr_d;
  logic [7:0]            lockCnt_q, lockCnt_d;
  logic                  gntA, gntB;

  logic [ADDR_WIDTH-1:0] romAddr_q;
  logic                  tag1Vld_q, tag1Port_q;
  logic                  tag2Vld_q, tag2Port_q;
  logic                  validA_q, validB_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  always_comb begin
    state_d   = state_q;
    rrPtr_d   = rrPtr_q;
    lockCnt_d = lockCnt_q;
    gntA      = 1'b0;
    gntB      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.reqA && (!bus.reqB || !rrPtr_q)) gntA = 1'b1;
        else if (bus.reqB)                       gntB = 1'b1;
      end
      OWN_A: begin
        if (!bus.reqA) begin
          state_d   = IDLE;
          lockCnt_d = 8'd0;
        end else if (lockCnt_q == MaxLock && bus.reqB) begin
          gntB = 1'b1;
        end else begin
          gntA = 1'b1;
        end
      end
      OWN_B: begin
        if (!bus.reqB) begin
          state_d   = IDLE;
          lockCnt_d = 8'd0;
        end else if (lockCnt_q == MaxLock && bus.reqA) begin
          gntA = 1'b1;
        end else begin
          gntB = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A grant from outside the winner's own burst starts a fresh ownership and passes the turn on.
    if (gntA) begin
      if (state_q == OWN_A) begin
        if (!bus.lockA) begin
          state_d   = IDLE;
          lockCnt_d = 8'd0;
        end else if (lockCnt_q != MaxLock) begin
          lockCnt_d = lockCnt_q + 8'd1;
        end
      end else begin
        rrPtr_d   = 1'b1;
        state_d   = bus.lockA ? OWN_A : IDLE;
        lockCnt_d = bus.lockA ? 8'd1 : 8'd0;
      end
    end

    if (gntB) begin
      if (state_q == OWN_B) begin
        if (!bus.lockB) begin
          state_d   = IDLE;
          lockCnt_d = 8'd0;
        end else if (lockCnt_q != MaxLock) begin
          lockCnt_d = lockCnt_q + 8'd1;
        end
      end else begin
        rrPtr_d   = 1'b0;
        state_d   = bus.lockB ? OWN_B : IDLE;
        lockCnt_d = bus.lockB ? 8'd1 : 8'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rrPtr_q   <= 1'b0;
      lockCnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      rrPtr_q   <= rrPtr_d;
      lockCnt_q <= lockCnt_d;
    end
  end

  // Two-stage tag pipeline tracks which port owns the ROM word arriving on romData_i.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      romAddr_q  <= '0;
      tag1Vld_q  <= 1'b0;
      tag1Port_q <= 1'b0;
      tag2Vld_q  <= 1'b0;
      tag2Port_q <= 1'b0;
      validA_q   <= 1'b0;
      validB_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      if (gntA || gntB) romAddr_q <= gntA ? bus.addrA : bus.addrB;
      tag1Vld_q  <= gntA || gntB;
      tag1Port_q <= gntB;
      tag2Vld_q  <= tag1Vld_q;
      tag2Port_q <= tag1Port_q;
      validA_q   <= tag2Vld_q && !tag2Port_q;
      validB_q   <= tag2Vld_q && tag2Port_q;
      if (tag2Vld_q) rdata_q <= romData_i;
    end
  end

  assign bus.gntA   = gntA && rst_n;
  assign bus.gntB   = gntB && rst_n;
  assign bus.validA = validA_q;
  assign bus.validB = validB_q;
  assign bus.rdata  = rdata_q;
  assign romAddr_o  = romAddr_q;

`ifdef ROM_ARB_STATS_EN
  logic [15:0] gntCntA_q, gntCntB_q, conflictCnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gntCntA_q     <= 16'd0;
      gntCntB_q     <= 16'd0;
      conflictCnt_q <= 16'd0;
    end else begin
      if (gntA && gntCntA_q != 16'hFFFF) gntCntA_q <= gntCntA_q + 16'd1;
      if (gntB && gntCntB_q != 16'hFFFF) gntCntB_q <= gntCntB_q + 16'd1;
      if (bus.reqA && bus.reqB && conflictCnt_q != 16'hFFFF)
        conflictCnt_q <= conflictCnt_q + 16'd1;
    end
  end

  assign gntCntA_o     = gntCntA_q;
  assign gntCntB_o     = gntCntB_q;
  assign conflictCnt_o = conflictCnt_q;
`endif

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Randomized + directed bench for rom_port_arbiter: queue-driven requesters, ownership-rule
// reference model, and a scoreboard monitor matching every VALID against expected data and latency.
module tb_rom_port_arbiter;

  localparam int MaxLock = 4;

  typedef struct {
    bit         idle;
    logic [7:0] addr;
    bit         lock;
  } reqItem_t;

  typedef struct {
    int         port;
    logic [7:0] data;
    int         due;
  } sbItem_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] romAddr;
  logic [7:0] romData = 8'h00;
  logic [7:0] romMem [256];

  int checkCnt = 0;
  int passCnt  = 0;
  int cyc      = 0;

  reqItem_t qA[$];
  reqItem_t qB[$];
  sbItem_t  sb[$];

  int    mOwner = -1;
  int    mTurn  = 0;
  int    mBurst = 0;
  int    mGntA = 0, mGntB = 0, mConflict = 0;
  bit    logOn = 1'b0;
  string grantLog = "";

  rom_port_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

`ifdef ROM_ARB_STATS_EN
  logic [15:0] gntCntA, gntCntB, conflictCnt;
`endif

  rom_port_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MAX_LOCK(MaxLock)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .romAddr_o (romAddr),
    .romData_i (romData)
`ifdef ROM_ARB_STATS_EN
    ,
    .gntCntA_o     (gntCntA),
    .gntCntB_o     (gntCntB),
    .conflictCnt_o (conflictCnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) romData <= romMem[romAddr];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCnt++;
    if (act === exp) passCnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic checkString(input string name, input string act, input string exp);
    checkCnt++;
    if (act == exp) passCnt++;
    else $display("[TB] FAIL %s: got \"%s\", expected \"%s\"", name, act, exp);
  endtask

  // Arbitration rules: free bus alternates on contention; an owner keeps the bus until it
  // unlocks or drops its request, except that a waiting peer wins once the burst hits MaxLock.
  function automatic int modelWinner(input bit rA, input bit rB);
    bit rq[2];
    rq[0] = rA;
    rq[1] = rB;
    if (mOwner < 0) begin
      if (rA && rB) return mTurn;
      if (rA) return 0;
      if (rB) return 1;
      return -1;
    end
    if (!rq[mOwner]) return -1;
    if (mBurst >= MaxLock && rq[1 - mOwner]) return 1 - mOwner;
    return mOwner;
  endfunction

  function automatic void modelUpdate(input int w, input bit rA, input bit rB, input bit lA, input bit lB);
    bit rq[2];
    bit lk[2];
    rq[0] = rA; rq[1] = rB;
    lk[0] = lA; lk[1] = lB;
    if (mOwner < 0 || (w >= 0 && w != mOwner)) begin
      if (w >= 0) begin
        mTurn  = 1 - w;
        mOwner = lk[w] ? w : -1;
        mBurst = lk[w] ? 1 : 0;
      end
    end else if (!rq[mOwner]) begin
      mOwner = -1;
      mBurst = 0;
    end else if (!lk[mOwner]) begin
      mOwner = -1;
      mBurst = 0;
    end else if (mBurst < MaxLock) begin
      mBurst++;
    end
  endfunction

  // One bus cycle: present queue heads, check grants at negedge, advance model at posedge.
  task automatic applyStimulus();
    bit  rA, rB, lA, lB;
    int  w;
    logic [7:0] aA, aB;
    rA = (qA.size() > 0) && !qA[0].idle;
    rB = (qB.size() > 0) && !qB[0].idle;
    aA = rA ? qA[0].addr : 8'($urandom);
    aB = rB ? qB[0].addr : 8'($urandom);
    lA = rA ? qA[0].lock : 1'($urandom);
    lB = rB ? qB[0].lock : 1'($urandom);
    bus.reqA = rA; bus.addrA = aA; bus.lockA = lA;
    bus.reqB = rB; bus.addrB = aB; bus.lockB = lB;
    @(negedge clk);
    w = modelWinner(rA, rB);
    checkOutput("gntA", {31'd0, bus.gntA}, {31'd0, w == 0});
    checkOutput("gntB", {31'd0, bus.gntB}, {31'd0, w == 1});
    if (w >= 0) begin
      sb.push_back('{port: w, data: romMem[(w == 0) ? aA : aB], due: cyc + 3});
      if (logOn) grantLog = {grantLog, (w == 0) ? "A" : "B"};
      if (w == 0) mGntA++;
      else        mGntB++;
    end
    if (rA && rB) mConflict++;
    @(posedge clk);
    modelUpdate(w, rA, rB, lA, lB);
    if (qA.size() > 0 && (qA[0].idle || w == 0)) void'(qA.pop_front());
    if (qB.size() > 0 && (qB[0].idle || w == 1)) void'(qB.pop_front());
    #1;
  endtask

  task automatic runUntilEmpty(input int maxSteps);
    int steps = 0;
    while ((qA.size() > 0 || qB.size() > 0) && steps < maxSteps) begin
      applyStimulus();
      steps++;
    end
    checkOutput("queuesDrained", qA.size() + qB.size(), 0);
  endtask

  task automatic drain();
    repeat (4) applyStimulus();
    checkOutput("scoreboardEmpty", sb.size(), 0);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    sb.delete();
    qA.delete();
    qB.delete();
    mOwner = -1; mTurn = 0; mBurst = 0;
    mGntA = 0; mGntB = 0; mConflict = 0;
    bus.reqA = 1'b1; bus.addrA = 8'h55; bus.lockA = 1'b1;
    bus.reqB = 1'b0; bus.addrB = 8'h00; bus.lockB = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checkOutput("rstGntA",    {31'd0, bus.gntA},   32'd0);
    checkOutput("rstValidA",  {31'd0, bus.validA}, 32'd0);
    checkOutput("rstValidB",  {31'd0, bus.validB}, 32'd0);
    checkOutput("rstRomAddr", {24'd0, romAddr},    32'd0);
    checkOutput("rstRdata",   {24'd0, bus.rdata},  32'd0);
    bus.reqA = 1'b0; bus.lockA = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every VALID must match the oldest outstanding transfer, on time.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.validA || bus.validB) begin
        sbItem_t it;
        checkOutput("validExclusive", {31'd0, bus.validA && bus.validB}, 32'd0);
        checkOutput("validExpected", {31'd0, sb.size() > 0}, 32'd1);
        if (sb.size() > 0) begin
          it = sb.pop_front();
          checkOutput("validPort", {31'd0, bus.validB}, it.port);
          checkOutput("rdata", {24'd0, bus.rdata}, {24'd0, it.data});
          checkOutput("latency", cyc, it.due);
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        checkOutput("validMissing", {31'd0, bus.validA || bus.validB}, 32'd1);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) romMem[i] = 8'($urandom);
    romMem[8'h10] = 8'h3C;
    bus.reqA = 1'b0; bus.addrA = 8'h00; bus.lockA = 1'b0;
    bus.reqB = 1'b0; bus.addrB = 8'h00; bus.lockB = 1'b0;
    doReset();

    // Contention without lock alternates starting from A after reset.
    for (int i = 0; i < 4; i++) begin
      qA.push_back('{idle: 1'b0, addr: 8'h20, lock: 1'b0});
      qB.push_back('{idle: 1'b0, addr: 8'h80, lock: 1'b0});
    end
    grantLog = "";
    logOn = 1'b1;
    runUntilEmpty(40);
    logOn = 1'b0;
    checkString("contentionOrder", grantLog, "ABABABAB");
    drain();

    qA.push_back('{idle: 1'b0, addr: 8'h10, lock: 1'b0});
    runUntilEmpty(10);
    drain();

    for (int i = 0; i < 4; i++) qA.push_back('{idle: 1'b0, addr: 8'(i), lock: 1'b0});
    runUntilEmpty(20);
    drain();

    // Reset with reads in flight must kill VALID at once and leave no late returns.
    for (int i = 0; i < 6; i++) qA.push_back('{idle: 1'b0, addr: 8'(8'h40 + i), lock: 1'b1});
    repeat (3) applyStimulus();
    rst_n = 1'b0;
    #1;
    checkOutput("midRstValidA", {31'd0, bus.validA}, 32'd0);
    checkOutput("midRstValidB", {31'd0, bus.validB}, 32'd0);
    doReset();
    drain();

    // Lock limit: A locked burst, B waiting, fresh reset so the turn starts at A.
    doReset();
    for (int i = 0; i < 8; i++) qA.push_back('{idle: 1'b0, addr: 8'(i), lock: (i != 7)});
    qB.push_back('{idle: 1'b0, addr: 8'h80, lock: 1'b0});
    grantLog = "";
    logOn = 1'b1;
    runUntilEmpty(40);
    logOn = 1'b0;
    checkString("lockLimitOrder", grantLog, "AAAABAAAA");
    drain();

    for (int i = 0; i < 160; i++)
      qA.push_back('{idle: ($urandom_range(3) == 0), addr: 8'($urandom), lock: ($urandom_range(2) == 0)});
    for (int i = 0; i < 130; i++)
      qB.push_back('{idle: ($urandom_range(3) == 0), addr: 8'($urandom), lock: ($urandom_range(2) == 0)});
    runUntilEmpty(3000);
    drain();

`ifdef ROM_ARB_STATS_EN
    checkOutput("statGntA",     {16'd0, gntCntA},     mGntA);
    checkOutput("statGntB",     {16'd0, gntCntB},     mGntB);
    checkOutput("statConflict", {16'd0, conflictCnt}, mConflict);
`endif

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
